adpll_lock_ctrl: RTL and testbench
==================================

# adpll_lock_ctrl

Frequency/lock controller for the ADAT receive bit-clock NCO. Consumes the synchronised transition pulse and the NCO accumulator MSB, and drives the NCO's frequency tuning word and phase-realign strobe. Runs a bang-bang frequency loop with acquire/track/holdover sequencing, and reports lock status to the frame decoder. Sits between the input synchroniser and the phase accumulator, all on `refclk`.

## Interface
Parameters:
- `ACCUM_SIZE`, 24: NCO accumulator and FTW width.
- `CLK_OVERSAMPLE_LOG2`, 4: log2 of refclk/bitclock ratio.
- `FTW_STEP`, 1: FTW increment/decrement per decision.
- `FTW_RANGE`, 2**(ACCUM_SIZE-8): allowed deviation; FTW is clamped to NOMINAL_FTW ± FTW_RANGE.
- `LOCK_COUNT`, 64: consecutive alternating decisions required to declare lock.
- `RUN_LIMIT`, 8: consecutive same-direction decisions in TRACK that declare loss of lock.
- `LOSS_TIMEOUT`, 256: refclk cycles without a transition before HOLD.

Ports:
- `refclk` in 1: sole clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: loop enable; low forces IDLE.
- `transition` in 1: one-cycle pulse per input edge, already synchronised.
- `accum_msb` in 1: NCO accumulator MSB, sampled when `transition`=1.
- `ftw` out ACCUM_SIZE: tuning word to NCO.
- `phase_reset` out 1: one-cycle strobe; NCO zeroes its accumulator.
- `locked` out 1: high only in TRACK.
- `lost_lock` out 1: one-cycle pulse on TRACK exit.
- `state` out 2: FSM state for debug.

## Operation
- NOMINAL_FTW = (2**ACCUM_SIZE-1) >> CLK_OVERSAMPLE_LOG2.
- Decision: on each `transition`, dir = up if `accum_msb`=1, else down.
  - ftw ± FTW_STEP, saturating at the clamp limits; a step past a limit leaves ftw at the limit.
  - Width-safe: compute in ACCUM_SIZE+1 bits before clamping.
- FSM states: IDLE=0, ACQUIRE=1, TRACK=2, HOLD=3.
- IDLE
  - ftw = NOMINAL_FTW; counters cleared.
  - `enable`=1 → ACQUIRE.
- ACQUIRE
  - Every transition: apply decision and assert `phase_reset`.
  - Alternation counter: increments when dir differs from the previous dir; otherwise resets to 0. The first decision after entry counts as 0.
  - Counter reaching LOCK_COUNT → TRACK.
- TRACK
  - Every transition: apply decision; no `phase_reset`.
  - Run counter: increments on same dir as previous, reset to 1 on change.
  - Run counter reaching RUN_LIMIT → ACQUIRE and pulse `lost_lock`.
- Silence counter
  - Cleared on every transition; otherwise increments, saturating.
  - Reaching LOSS_TIMEOUT in ACQUIRE or TRACK → HOLD. Pulse `lost_lock` if leaving TRACK.
- HOLD
  - ftw frozen at its last value.
  - Next transition → ACQUIRE with `phase_reset`. No decision is applied on that edge.
- `enable`=0 in any state → IDLE on the next edge. No `lost_lock` pulse.

## Timing
- Reset values: ftw=NOMINAL_FTW, phase_reset=0, locked=0, lost_lock=0, state=IDLE; all counters 0.
- All outputs are registered.
- ftw and phase_reset update the cycle after the `transition` pulse (1-cycle latency). locked and state change in that same cycle.
- Transition and timeout in the same cycle: the transition wins, the silence counter clears, and no HOLD entry occurs.
- RUN_LIMIT and LOCK_COUNT reached on the same edge cannot happen (mutually exclusive states).
- Transitions on back-to-back cycles: each is processed, one decision per cycle.
- `enable` low has priority over all transitions and timeouts in the same cycle.
- Async reset mid-operation returns every output to its reset value immediately. Operation resumes from IDLE on the first edge after deassertion.

## Structure
- Package `adpll_pkg`:
  - state enum (IDLE/ACQUIRE/TRACK/HOLD, 2-bit);
  - NOMINAL_FTW computation function;
  - clamp-limit constants derived from ACCUM_SIZE and FTW_RANGE.
- Sub-module `adpll_lock_detect`:
  - holds the previous dir, the alternation/run counters and the silence counter;
  - outputs `lock_hit`, `run_hit`, `timeout_hit` to the FSM.
- FSM and ftw register live in the top.

## Test plan
- Reset, then enable=1 with no transitions: ftw=0x0FFFFF, state goes IDLE→ACQUIRE, and HOLD is reached exactly 256 cycles after the last counter clear; locked stays 0.
- Alternating accum_msb on transitions every 16 cycles: phase_reset pulses on each edge, locked rises the cycle after the 64th alternation, and ftw dithers between 0x0FFFFF and 0x100000.
- In TRACK, feed 8 consecutive accum_msb=1 decisions: ftw rises by 8, then lost_lock pulses once, state=ACQUIRE and locked=0.
- Drive accum_msb=1 for more than FTW_RANGE decisions: ftw saturates at NOMINAL_FTW+0x10000 and holds there.
- In TRACK, stop transitions for 256 cycles: HOLD is entered with a lost_lock pulse and ftw frozen. The next transition gives phase_reset=1, state=ACQUIRE and an unchanged ftw.
- Deassert enable mid-TRACK, and separately assert reset mid-ACQUIRE: the next cycle (respectively immediately) shows ftw=NOMINAL_FTW, locked=0 and no lost_lock pulse.

Source files
------------

// File: rtl/adpll_pkg.sv
// Shared types and tuning-word limit helpers for the ADAT bit-clock lock controller.
package adpll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_HOLD    = 2'd3
    } adpll_state_e;

    function automatic logic [63:0] nominal_ftw(input int unsigned accum_size,
                                                input int unsigned os_log2);
        return ((64'd1 << accum_size) - 64'd1) >> os_log2;
    endfunction

    // Upper clamp limit, never above the accumulator's all-ones value.
    function automatic logic [63:0] ftw_hi(input int unsigned accum_size,
                                           input int unsigned os_log2,
                                           input int unsigned rng);
        logic [63:0] lim;
        logic [63:0] all_ones;
        lim      = nominal_ftw(accum_size, os_log2) + 64'(rng);
        all_ones = (64'd1 << accum_size) - 64'd1;
        return (lim > all_ones) ? all_ones : lim;
    endfunction

    function automatic logic [63:0] ftw_lo(input int unsigned accum_size,
                                           input int unsigned os_log2,
                                           input int unsigned rng);
        logic [63:0] nom;
        nom = nominal_ftw(accum_size, os_log2);
        return (nom > 64'(rng)) ? nom - 64'(rng) : 64'd0;
    endfunction

endpackage

// File: rtl/adpll_lock_detect.sv
// Decision history for the lock FSM: alternation/run counters and transition-silence timer.
// Hit outputs are combinational so the FSM can act on the same edge as the decision.
module adpll_lock_detect #(
    parameter int unsigned LOCK_COUNT   = 64,
    parameter int unsigned RUN_LIMIT    = 8,
    parameter int unsigned LOSS_TIMEOUT = 256
) (
    input  logic refclk,
    input  logic reset,
    input  logic clear,
    input  logic transition,
    input  logic dir_up,
    output logic lock_hit,
    output logic run_hit,
    output logic timeout_hit
);

    localparam int unsigned AW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned RW = $clog2(RUN_LIMIT + 1);
    localparam int unsigned SW = $clog2(LOSS_TIMEOUT + 1);
    localparam logic [AW-1:0] ALT_MAX  = AW'(LOCK_COUNT);
    localparam logic [RW-1:0] RUN_MAX  = RW'(RUN_LIMIT);
    localparam logic [SW-1:0] SIL_MAX  = SW'(LOSS_TIMEOUT);
    localparam logic [SW-1:0] SIL_LAST = SW'(LOSS_TIMEOUT - 1);

    logic          prev_vld_q, prev_vld_d;
    logic          prev_up_q, prev_up_d;
    logic [AW-1:0] alt_cnt_q, alt_cnt_d, alt_nxt;
    logic [RW-1:0] run_cnt_q, run_cnt_d, run_nxt;
    logic [SW-1:0] sil_cnt_q, sil_cnt_d;
    logic          changed;

    always_comb begin
        changed = prev_vld_q && (dir_up != prev_up_q);
        alt_nxt = '0;
        run_nxt = RW'(1);
        if (changed) begin
            alt_nxt = (alt_cnt_q == ALT_MAX) ? alt_cnt_q : alt_cnt_q + AW'(1);
        end else if (prev_vld_q) begin
            run_nxt = (run_cnt_q == RUN_MAX) ? run_cnt_q : run_cnt_q + RW'(1);
        end

        lock_hit    = transition && (alt_nxt == ALT_MAX);
        run_hit     = transition && (run_nxt == RUN_MAX);
        // A transition in the timeout cycle wins.
        timeout_hit = !transition && (sil_cnt_q == SIL_LAST);

        prev_vld_d = prev_vld_q;
        prev_up_d  = prev_up_q;
        alt_cnt_d  = alt_cnt_q;
        run_cnt_d  = run_cnt_q;
        sil_cnt_d  = (sil_cnt_q == SIL_MAX) ? sil_cnt_q : sil_cnt_q + SW'(1);
        if (clear) begin
            prev_vld_d = 1'b0;
            prev_up_d  = 1'b0;
            alt_cnt_d  = '0;
            run_cnt_d  = '0;
            sil_cnt_d  = '0;
        end else if (transition) begin
            prev_vld_d = 1'b1;
            prev_up_d  = dir_up;
            alt_cnt_d  = alt_nxt;
            run_cnt_d  = run_nxt;
            sil_cnt_d  = '0;
        end
    end

    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            prev_vld_q <= 1'b0;
            prev_up_q  <= 1'b0;
            alt_cnt_q  <= '0;
            run_cnt_q  <= '0;
            sil_cnt_q  <= '0;
        end else begin
            prev_vld_q <= prev_vld_d;
            prev_up_q  <= prev_up_d;
            alt_cnt_q  <= alt_cnt_d;
            run_cnt_q  <= run_cnt_d;
            sil_cnt_q  <= sil_cnt_d;
        end
    end

endmodule

// File: rtl/adpll_lock_ctrl.sv
// Bang-bang frequency/lock controller for the ADAT bit-clock NCO (idle/acquire/track/hold).
// All outputs registered; decisions appear one refclk after the transition pulse.
module adpll_lock_ctrl
    import adpll_pkg::*;
#(
    parameter int unsigned ACCUM_SIZE          = 24,
    parameter int unsigned CLK_OVERSAMPLE_LOG2 = 4,
    parameter int unsigned FTW_STEP            = 1,
    parameter int unsigned FTW_RANGE           = 2**(ACCUM_SIZE-8),
    parameter int unsigned LOCK_COUNT          = 64,
    parameter int unsigned RUN_LIMIT           = 8,
    parameter int unsigned LOSS_TIMEOUT        = 256
) (
    input  logic                  refclk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  transition,
    input  logic                  accum_msb,
    output logic [ACCUM_SIZE-1:0] ftw,
    output logic                  phase_reset,
    output logic                  locked,
    output logic                  lost_lock,
    output logic [1:0]            state
);

    localparam logic [ACCUM_SIZE-1:0] NOMINAL_FTW =
        ACCUM_SIZE'(nominal_ftw(ACCUM_SIZE, CLK_OVERSAMPLE_LOG2));
    localparam logic [ACCUM_SIZE:0] FTW_MAX =
        (ACCUM_SIZE+1)'(ftw_hi(ACCUM_SIZE, CLK_OVERSAMPLE_LOG2, FTW_RANGE));
    localparam logic [ACCUM_SIZE:0] FTW_MIN =
        (ACCUM_SIZE+1)'(ftw_lo(ACCUM_SIZE, CLK_OVERSAMPLE_LOG2, FTW_RANGE));
    localparam logic [ACCUM_SIZE:0] STEP = (ACCUM_SIZE+1)'(FTW_STEP);

    adpll_state_e          state_q, state_d;
    logic [ACCUM_SIZE-1:0] ftw_q, ftw_d, ftw_dec;
    logic [ACCUM_SIZE:0]   ftw_sum, ftw_diff;
    logic                  phase_reset_q, phase_reset_d;
    logic                  locked_q, locked_d;
    logic                  lost_lock_q, lost_lock_d;
    logic                  lock_hit, run_hit, timeout_hit, det_clear;

    // Counters restart whenever the FSM changes state or sits in IDLE.
    assign det_clear = (state_q == ST_IDLE) || (state_d != state_q);

    adpll_lock_detect #(
        .LOCK_COUNT  (LOCK_COUNT),
        .RUN_LIMIT   (RUN_LIMIT),
        .LOSS_TIMEOUT(LOSS_TIMEOUT)
    ) u_detect (
        .refclk     (refclk),
        .reset      (reset),
        .clear      (det_clear),
        .transition (transition),
        .dir_up     (accum_msb),
        .lock_hit   (lock_hit),
        .run_hit    (run_hit),
        .timeout_hit(timeout_hit)
    );

    // One extra bit keeps the step from wrapping before the clamp.
    always_comb begin
        ftw_sum  = {1'b0, ftw_q} + STEP;
        ftw_diff = {1'b0, ftw_q} - STEP;
        if (accum_msb) begin
            ftw_dec = (ftw_sum > FTW_MAX) ? FTW_MAX[ACCUM_SIZE-1:0] : ftw_sum[ACCUM_SIZE-1:0];
        end else begin
            ftw_dec = (ftw_diff[ACCUM_SIZE] || (ftw_diff < FTW_MIN)) ?
                      FTW_MIN[ACCUM_SIZE-1:0] : ftw_diff[ACCUM_SIZE-1:0];
        end
    end

    always_comb begin
        state_d       = state_q;
        ftw_d         = ftw_q;
        phase_reset_d = 1'b0;
        lost_lock_d   = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            ftw_d   = NOMINAL_FTW;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                    ftw_d   = NOMINAL_FTW;
                end
                ST_ACQUIRE: begin
                    if (transition) begin
                        ftw_d         = ftw_dec;
                        phase_reset_d = 1'b1;
                        if (lock_hit) state_d = ST_TRACK;
                    end else if (timeout_hit) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_TRACK: begin
                    if (transition) begin
                        ftw_d = ftw_dec;
                        if (run_hit) begin
                            state_d     = ST_ACQUIRE;
                            lost_lock_d = 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state_d     = ST_HOLD;
                        lost_lock_d = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (transition) begin
                        state_d       = ST_ACQUIRE;
                        phase_reset_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        locked_d = (state_d == ST_TRACK);
    end

    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ftw_q         <= NOMINAL_FTW;
            phase_reset_q <= 1'b0;
            locked_q      <= 1'b0;
            lost_lock_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ftw_q         <= ftw_d;
            phase_reset_q <= phase_reset_d;
            locked_q      <= locked_d;
            lost_lock_q   <= lost_lock_d;
        end
    end

    assign ftw         = ftw_q;
    assign phase_reset = phase_reset_q;
    assign locked      = locked_q;
    assign lost_lock   = lost_lock_q;
    assign state       = state_q;

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// Directed bench for adpll_lock_ctrl with a queue-based scoreboard of expected outputs.
module tb_adpll_lock_ctrl;

    localparam logic [23:0] NOM  = 24'h0FFFFF;
    localparam logic [23:0] MAXF = 24'h10FFFF;
    localparam logic [23:0] MINF = 24'h0EFFFF;
    localparam logic [1:0]  S_I = 2'd0, S_A = 2'd1, S_T = 2'd2, S_H = 2'd3;

    typedef struct packed {
        logic [23:0] ftw;
        logic        pr;
        logic        lk;
        logic        ll;
        logic [1:0]  st;
    } obs_t;

    logic        refclk = 1'b0;
    logic        reset, enable, transition, accum_msb;
    logic [23:0] ftw;
    logic        phase_reset, locked, lost_lock;
    logic [1:0]  state;

    obs_t        sb_q[$];
    string       tag_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [23:0] e_ftw;
    logic [1:0]  e_st;

    adpll_lock_ctrl dut (
        .refclk     (refclk),
        .reset      (reset),
        .enable     (enable),
        .transition (transition),
        .accum_msb  (accum_msb),
        .ftw        (ftw),
        .phase_reset(phase_reset),
        .locked     (locked),
        .lost_lock  (lost_lock),
        .state      (state)
    );

    always #5 refclk = ~refclk;

    function automatic logic [23:0] model_step(input logic [23:0] f, input bit up);
        if (up) return (f >= MAXF) ? MAXF : f + 24'd1;
        return (f <= MINF) ? MINF : f - 24'd1;
    endfunction

    task automatic push_exp(input bit pr, input bit ll, input string tag);
        obs_t e;
        e.ftw = e_ftw;
        e.pr  = pr;
        e.lk  = (e_st == S_T);
        e.ll  = ll;
        e.st  = e_st;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        obs_t  o, e;
        string t;
        o = {ftw, phase_reset, locked, lost_lock, state};
        tests++;
        if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty: observed %h with no expected entry", o);
        end else begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            assert (o === e) else begin
                fails++;
                $error("FAIL %s: observed ftw=%h pr=%b lk=%b ll=%b st=%0d, expected ftw=%h pr=%b lk=%b ll=%b st=%0d",
                       t, o.ftw, o.pr, o.lk, o.ll, o.st, e.ftw, e.pr, e.lk, e.ll, e.st);
            end
        end
    endtask

    task automatic cyc(input bit tr, input bit msb, input bit pr, input bit ll, input string tag);
        transition = tr;
        accum_msb  = msb;
        push_exp(pr, ll, tag);
        @(posedge refclk);
        #1;
        check_out();
    endtask

    task automatic quiet(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    // 65 alternating decisions: the first counts 0, the 65th makes the 64th alternation.
    task automatic acquire_lock(input bit first_up, input int gap);
        bit up;
        for (int k = 1; k <= 65; k++) begin
            up    = (k % 2 == 1) ? first_up : !first_up;
            e_ftw = model_step(e_ftw, up);
            e_st  = (k == 65) ? S_T : S_A;
            cyc(1'b1, up, 1'b1, 1'b0, "acq_alternate");
            quiet(gap, "acq_gap");
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; transition = 1'b0; accum_msb = 1'b0;
        e_ftw = NOM; e_st = S_I;
        repeat (2) @(posedge refclk);
        #1;
        push_exp(1'b0, 1'b0, "reset_state");
        check_out();
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "idle_disabled");

        // Enable with no transitions: HOLD exactly 256 cycles after the IDLE clear.
        enable = 1'b1; e_st = S_A;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "enter_acquire");
        quiet(255, "acq_silence");
        e_st = S_H;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "acq_timeout_hold");
        quiet(4, "hold_wait");
        e_st = S_A;
        cyc(1'b1, 1'b1, 1'b1, 1'b0, "hold_exit_no_decision");
        quiet(15, "gap");

        // Alternating decisions every 16 cycles, starting up: dither 0x100000/0x0FFFFF.
        acquire_lock(1'b1, 15);

        // Eight back-to-back up decisions in TRACK.
        for (int j = 1; j <= 8; j++) begin
            e_ftw = model_step(e_ftw, 1'b1);
            if (j == 8) e_st = S_A;
            cyc(1'b1, 1'b1, 1'b0, (j == 8), "track_run_limit");
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "lost_lock_single_pulse");

        // Ramp up past the clamp; ftw must stop at NOMINAL+0x10000.
        for (int i = 0; i < 65540; i++) begin
            e_ftw = model_step(e_ftw, 1'b1);
            cyc(1'b1, 1'b1, 1'b1, 1'b0, "ramp_saturate");
        end

        // Relock at the limit, then let TRACK time out.
        acquire_lock(1'b1, 0);
        quiet(255, "track_silence");
        e_st = S_H;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "track_timeout_hold");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "hold_no_repeat_pulse");
        quiet(3, "hold_frozen");
        e_st = S_A;
        cyc(1'b1, 1'b0, 1'b1, 1'b0, "hold_exit_ftw_kept");

        // Transition lands in the cycle the timeout would have fired.
        quiet(255, "acq_quiet");
        e_ftw = model_step(e_ftw, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, "transition_beats_timeout");

        // Back to TRACK, then drop enable together with a transition.
        acquire_lock(1'b0, 0);
        quiet(2, "track_before_disable");
        enable = 1'b0; e_ftw = NOM; e_st = S_I;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "disable_priority");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "idle_stays");
        enable = 1'b1; e_st = S_A;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "reenable");
        e_ftw = model_step(e_ftw, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, "acq_decision_1");
        e_ftw = model_step(e_ftw, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, "acq_decision_2");

        // Asynchronous reset mid-ACQUIRE, checked before the next edge.
        transition = 1'b0;
        #2 reset = 1'b1;
        #1;
        e_ftw = NOM; e_st = S_I;
        push_exp(1'b0, 1'b0, "async_reset_immediate");
        check_out();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "reset_held");
        reset = 1'b0; e_st = S_A;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "resume_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
